icache_ctrl: RTL

//  Direct-mapped instruction cache and refill controller serving the fetch stage's 128-bit

---
 rtl/icache_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache with a 4-beat refill controller.
// The fetch side gets a whole 128-bit line on a hit in the same cycle. On a miss,
// fetch is stalled while the line is read word by word from the memory port.
// The line is then written into the arrays. An invalidate that arrives during a
// refill makes the refilled line land as invalid.
module icache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_rd,
  output logic [LINE_WIDTH-1:0] cpu_data,
  output logic                  cpu_waitrequest,
  input  logic                  invalidate,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [31:0]           mem_data,
  input  logic                  mem_waitrequest
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 4;
  localparam int LA_W  = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [LINES-1:0]      valid_r;
  logic [TAG_W-1:0]      tag_mem_r  [LINES];
  logic [LINE_WIDTH-1:0] data_mem_r [LINES];
  logic [LA_W-1:0]       line_addr_r;
  logic [1:0]            beat_r;
  logic [31:0]           fill_r [4];
  logic                  drop_r;

  logic [INDEX_BITS-1:0] cpu_idx_s;
  logic [INDEX_BITS-1:0] fill_idx_s;
  logic [TAG_W-1:0]      cpu_tag_s;
  logic                  hit_s;
  logic                  miss_s;
  logic                  beat_ack_s;
  logic                  unused_s;

  assign cpu_idx_s  = cpu_addr[INDEX_BITS+3:4];
  assign cpu_tag_s  = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+4];
  assign fill_idx_s = line_addr_r[INDEX_BITS-1:0];
  // Byte offset within the line is irrelevant: the whole line is always returned.
  assign unused_s   = ^cpu_addr[3:0];

  // The arrays are read asynchronously, so a hit is resolved in the requesting cycle.
  assign hit_s      = valid_r[cpu_idx_s] & (tag_mem_r[cpu_idx_s] == cpu_tag_s);
  assign miss_s     = cpu_rd & ~hit_s;
  assign mem_rd     = (state_r == ST_REFILL);
  assign beat_ack_s = mem_rd & ~mem_waitrequest;
  assign mem_addr   = mem_rd ? {line_addr_r, beat_r, 2'b00} : {ADDR_WIDTH{1'b0}};

  assign cpu_waitrequest = (state_r != ST_IDLE) | miss_s;
  assign cpu_data        = ((state_r == ST_IDLE) && hit_s) ? data_mem_r[cpu_idx_s]
                                                          : {LINE_WIDTH{1'b0}};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: detect miss, count accepted beats, then one write cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_s) begin
          state_s = ST_REFILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REFILL: begin
        if (beat_ack_s && (beat_r == 2'd3)) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_REFILL;
        end
      end
      ST_WRITE: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Refill datapath: latch line address, collect beats, and track invalidate-during-refill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_addr_r <= {LA_W{1'b0}};
      beat_r      <= 2'd0;
      drop_r      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fill_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_s) begin
            line_addr_r <= cpu_addr[ADDR_WIDTH-1:4];
            beat_r      <= 2'd0;
            drop_r      <= 1'b0;
          end
        end
        ST_REFILL: begin
          // Beat 3 wraps the counter to 0 on the way into the write cycle.
          if (beat_ack_s) begin
            fill_r[beat_r] <= mem_data;
            beat_r         <= beat_r + 2'd1;
          end
          if (invalidate) begin
            drop_r <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (invalidate) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          beat_r <= 2'd0;
        end
      endcase
    end
  end

  // Valid bits: invalidate clears everything and overrides the line being written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= {LINES{1'b0}};
    end else if (invalidate) begin
      valid_r <= {LINES{1'b0}};
    end else if (state_r == ST_WRITE) begin
      valid_r[fill_idx_s] <= ~drop_r;
    end
  end

  // Tag and data arrays: the completed line replaces whatever occupied its index.
  always_ff @(posedge clock) begin
    if (state_r == ST_WRITE) begin
      tag_mem_r[fill_idx_s]  <= line_addr_r[LA_W-1:INDEX_BITS];
      data_mem_r[fill_idx_s] <= {fill_r[0], fill_r[1], fill_r[2], fill_r[3]};
    end
  end

endmodule
